// File: rtl/counter_cluster_sched_pkg.sv
// Shared constants for the segmented counter cluster: opcodes, FSM encoding, segment layout.
package counter_cluster_sched_pkg;

    localparam logic [1:0] OP_INC   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam int unsigned SEG0_LSB = 0;
    localparam int unsigned SEG0_W   = 8;
    localparam int unsigned SEG1_LSB = 8;
    localparam int unsigned SEG1_W   = 12;
    localparam int unsigned SEG2_LSB = 20;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEG0 = 3'd1,
        ST_SEG1 = 3'd2,
        ST_SEG2 = 3'd3,
        ST_RESP = 3'd4
    } state_e;

endpackage

// File: rtl/counter_cluster_sched_if.sv
// Requester-side bus of the shared counter: per-requester request/op/data plus grant and results.
interface counter_cluster_sched_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned N    = 36
);
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [N*NREQ-1:0] wdata;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [N-1:0]      rdata;
    logic [N-1:0]      count;
    logic              busy;

    modport master (
        output req, op, wdata,
        input  gnt, done, rdata, count, busy
    );

    modport slave (
        input  req, op, wdata,
        output gnt, done, rdata, count, busy
    );
endinterface

// File: rtl/counter_cluster_sched_rr_arbiter.sv
// Combinational round-robin selector: first active request at or after the pointer wins.
module rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_c_o,
    output logic [PW-1:0]   idx_c_o,
    output logic            any_c_o
);

    always_comb begin
        int unsigned j;
        logic        found;
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        j       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr_i) + i) % NREQ;
            if (!found && req_i[j]) begin
                found      = 1'b1;
                gnt_c_o[j] = 1'b1;
                idx_c_o    = PW'(j);
            end
        end
        any_c_o = found;
    end

endmodule

// File: rtl/counter_cluster_sched.sv
// Shared N-bit counter with round-robin access; INC ripples carry one segment per cycle.
module counter_cluster_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned N    = 36
) (
    input  logic                    clock0,
    input  logic                    reset,
    counter_cluster_sched_if.slave  bus
);
    import counter_cluster_sched_pkg::*;

    localparam int unsigned PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SEG2_W = N - SEG2_LSB;

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic            done_q;
    logic            busy_q;
    logic [N-1:0]    count_q;
    logic [N-1:0]    rdata_q;
    logic [N-1:0]    wdata_q;
    logic [1:0]      op_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   ptr_d;

    logic [NREQ-1:0] arb_gnt;
    logic [PW-1:0]   arb_idx;
    logic            arb_any;
    logic [1:0]      op_sel;
    logic [N-1:0]    wdata_sel;

    logic [SEG0_W-1:0] seg0_inc;
    logic [SEG1_W-1:0] seg1_inc;
    logic [SEG2_W-1:0] seg2_inc;
    logic              seg0_max;
    logic              seg1_max;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr_arbiter (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_c_o (arb_gnt),
        .idx_c_o (arb_idx),
        .any_c_o (arb_any)
    );

    // One-hot mux of the winner's opcode and load value.
    always_comb begin
        op_sel    = '0;
        wdata_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (arb_gnt[k]) begin
                op_sel    = bus.op[2*k +: 2];
                wdata_sel = bus.wdata[N*k +: N];
            end
        end
    end

    always_comb begin
        ptr_d    = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
        seg0_inc = count_q[SEG0_LSB +: SEG0_W] + SEG0_W'(1);
        seg1_inc = count_q[SEG1_LSB +: SEG1_W] + SEG1_W'(1);
        seg2_inc = count_q[SEG2_LSB +: SEG2_W] + SEG2_W'(1);
        seg0_max = &count_q[SEG0_LSB +: SEG0_W];
        seg1_max = &count_q[SEG1_LSB +: SEG1_W];
    end

    // done is registered off RESP, so it appears the cycle after RESP while gnt is still held.
    always_ff @(posedge clock0) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            op_q    <= OP_INC;
            ptr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q   <= arb_gnt;
                        op_q    <= op_sel;
                        wdata_q <= wdata_sel;
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        state_q <= ST_SEG0;
                    end else begin
                        gnt_q <= '0;
                    end
                end
                ST_SEG0: begin
                    state_q <= ST_RESP;
                    case (op_q)
                        OP_INC: begin
                            count_q[SEG0_LSB +: SEG0_W] <= seg0_inc;
                            if (seg0_max) state_q <= ST_SEG1;
                        end
                        OP_LOAD:  count_q <= wdata_q;
                        OP_CLEAR: count_q <= '0;
                        default:  rdata_q <= count_q;
                    endcase
                end
                ST_SEG1: begin
                    count_q[SEG1_LSB +: SEG1_W] <= seg1_inc;
                    state_q <= seg1_max ? ST_SEG2 : ST_RESP;
                end
                ST_SEG2: begin
                    count_q[SEG2_LSB +: SEG2_W] <= seg2_inc;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = count_q;
    assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_counter_cluster_sched.sv
// Directed bench for counter_cluster_sched: latency, carry, arbitration order, READ/CLEAR, mid-op reset.
module tb_counter_cluster_sched;

    localparam int unsigned NREQ = 4;
    localparam int unsigned N    = 36;
    localparam logic [1:0] T_INC = 2'b00, T_LOAD = 2'b01, T_CLEAR = 2'b10, T_READ = 2'b11;

    logic clock0;
    logic reset;
    int   n_cmp, n_err, multi_gnt;
    int   order[5];
    int   exp_ord[5] = '{0, 1, 2, 3, 0};

    counter_cluster_sched_if #(.NREQ(NREQ), .N(N)) bus ();

    counter_cluster_sched #(.NREQ(NREQ), .N(N)) dut (
        .clock0 (clock0),
        .reset  (reset),
        .bus    (bus)
    );

    initial clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    always @(negedge clock0) if ($countones(bus.gnt) > 1) multi_gnt++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock0);
        #1;
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] g);
        int r = -1;
        for (int i = 0; i < NREQ; i++) if (g[i]) r = i;
        return r;
    endfunction

    // Issue one op from requester k, scramble its inputs after grant, and time the done pulse.
    task automatic run_op(input int k, input logic [1:0] opc, input logic [N-1:0] data,
                          input int exp_lat, input string tag);
        int lat = 0;
        bit seen = 0;
        bus.req = '0;
        bus.req[k] = 1'b1;
        bus.op[2*k +: 2] = opc;
        bus.wdata[N*k +: N] = data;
        tick();
        chk({tag, "_gnt"}, 64'(bus.gnt), 64'(1 << k));
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        bus.req = '0;
        bus.op[2*k +: 2] = ~opc;
        bus.wdata[N*k +: N] = ~data;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            lat++;
            if (bus.done) seen = 1;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_gnt_at_done"}, 64'(bus.gnt), 64'(1 << k));
        tick();
        chk({tag, "_gnt_clr"}, 64'(bus.gnt), 64'd0);
        chk({tag, "_done_clr"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int  ndone;
        bit  saw_done;
        n_cmp = 0; n_err = 0; multi_gnt = 0;
        bus.req = '0; bus.op = '0; bus.wdata = '0;
        reset = 1'b1;
        tick(); tick();
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_gnt",   64'(bus.gnt),   64'd0);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        reset = 1'b0;

        run_op(0, T_INC, '0, 2, "inc0");
        chk("inc0_count", 64'(bus.count), 64'h1);

        run_op(1, T_LOAD, 36'h0_000F_FFFF, 2, "ld_fffff");
        chk("ld_fffff_count", 64'(bus.count), 64'h0_000F_FFFF);
        run_op(2, T_INC, '0, 4, "inc_c2");
        chk("inc_c2_count", 64'(bus.count), 64'h0_0010_0000);

        run_op(3, T_LOAD, 36'hF_FFFF_FFFF, 2, "ld_max");
        run_op(0, T_INC, '0, 4, "inc_wrap");
        chk("inc_wrap_count", 64'(bus.count), 64'h0);

        run_op(1, T_LOAD, 36'h0_0000_00FF, 2, "ld_ff");
        run_op(2, T_INC, '0, 3, "inc_c1");
        chk("inc_c1_count", 64'(bus.count), 64'h100);

        run_op(3, T_CLEAR, '0, 2, "clr_a");
        chk("clr_a_count", 64'(bus.count), 64'h0);

        // All four requesting INC continuously; order recorded at each done pulse.
        for (int i = 0; i < 5; i++) order[i] = -1;
        bus.req = '1; bus.op = '0;
        ndone = 0;
        for (int c = 0; c < 40 && ndone < 5; c++) begin
            tick();
            if (bus.done) begin
                order[ndone] = onehot_idx(bus.gnt);
                ndone++;
                if (ndone == 5) bus.req = '0;
            end
        end
        bus.req = '0;
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order%0d", i), 64'(order[i]), 64'(exp_ord[i]));
        chk("rr_ndone", 64'(ndone), 64'd5);
        chk("rr_count", 64'(bus.count), 64'd5);
        tick(); tick();

        run_op(2, T_LOAD, 36'h1_2345_6789, 2, "ld_pat");
        run_op(1, T_READ, '0, 2, "rd");
        chk("rd_rdata", 64'(bus.rdata), 64'h1_2345_6789);
        run_op(0, T_CLEAR, '0, 2, "clr_b");
        chk("clr_b_count", 64'(bus.count), 64'h0);
        chk("clr_b_rdata", 64'(bus.rdata), 64'h1_2345_6789);

        // Reset while the INC is sitting in SEG1.
        run_op(3, T_LOAD, 36'h5_0000_00FF, 2, "ld_r");
        bus.req = 4'b0100; bus.op[5:4] = T_INC;
        tick();
        chk("r_gnt", 64'(bus.gnt), 64'h4);
        bus.req = '0;
        tick();
        chk("r_mid_count", 64'(bus.count), 64'h5_0000_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("r_count", 64'(bus.count), 64'h0);
        chk("r_gnt0",  64'(bus.gnt),   64'h0);
        chk("r_busy",  64'(bus.busy),  64'h0);
        chk("r_rdata", 64'(bus.rdata), 64'h0);
        saw_done = bus.done;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.done) saw_done = 1;
        end
        chk("r_no_done", 64'(saw_done), 64'd0);
        bus.req = '1; bus.op = '0;
        tick();
        chk("r_next_gnt", 64'(bus.gnt), 64'h1);
        bus.req = '0;
        tick(); tick(); tick();
        chk("r_post_count", 64'(bus.count), 64'h1);

        chk("onehot", 64'(multi_gnt), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
